// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART receive path.
//   uart_rx_state_e  : receiver FSM states
//   UART_DATA_BITS   : default data bits per frame
//   UART_OVERSAMPLE  : default os_tick strobes per bit period
//   uart_cnt_width() : width of the oversample counter for a given OVERSAMPLE
//   uart_majority3() : 2-of-3 vote used when majority sampling is built in
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_rx_state_e;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;

    // ceil(log2(oversample)), never less than 1 bit.
    function automatic int uart_cnt_width(input int oversample);
        int w;
        w = 1;
        while ((1 << w) < oversample) begin
            w = w + 1;
        end
        return w;
    endfunction

    function automatic logic uart_majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchroniser for an asynchronous single-bit input.
//   clk        : destination clock
//   rst_n      : asynchronous active-low reset; both flops load RESET_VAL
//   d_i        : asynchronous input
//   q_o        : synchronised output (two clk cycles of latency)
// Parameter RESET_VAL selects the idle level so a reset does not look like
// an edge on the line.
// -----------------------------------------------------------------------------
module uart_rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1-style UART receiver (start, DATA_BITS data LSB-first, one stop bit)
// timed by an external oversample strobe, with a one-entry valid/ready
// holding register.
//
// Ports:
//   clk        : system clock, all logic on posedge
//   rst_n      : asynchronous active-low reset
//   os_tick    : one-clk strobe at bit rate x OVERSAMPLE
//   rxd        : serial input, asynchronous, idles high
//   rx_data    : received word, stable while rx_valid is high
//   rx_valid   : word available, held until accepted
//   rx_ready   : consumer accepts the word when rx_valid && rx_ready
//   frame_err  : one-clk pulse, stop bit sampled low (word discarded)
//   rx_overrun : one-clk pulse, frame completed while the holding register
//                was full and not being accepted (new word dropped)
//   rx_busy    : high whenever the FSM is not in IDLE
//
// Build option:
//   UART_RX_MAJORITY_EN : every decision (start validation, data bit, stop
//   bit) becomes a 2-of-3 vote of the synchronised line on the three
//   os_ticks ending at the decision point. Decision timing is unchanged.
//   Undefined: a single sample at the decision point.
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 os_tick,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 rx_overrun,
    output logic                 rx_busy
);

    localparam int               CNT_W    = uart_cnt_width(OVERSAMPLE);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam int               IDX_W    = 4;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic                 rxs;
    logic                 bit_val;

    uart_rx_state_e       state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [IDX_W-1:0]     bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 frame_err_q;
    logic                 rx_overrun_q;
    logic                 rx_busy_q;

    uart_rx_sync #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (rxd),
        .q_o   (rxs)
    );

`ifdef UART_RX_MAJORITY_EN
    // The two previous os_tick samples of rxs. Every decision point sits at
    // least two ticks into its state, so both history bits always belong to
    // the bit being decided.
    logic [1:0] hist_q;
    logic [1:0] hist_d;

    assign hist_d = {hist_q[0], rxs};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= 2'b11;
        end else if (os_tick) begin
            hist_q <= hist_d;
        end
    end

    assign bit_val = uart_majority3(hist_q[1], hist_q[0], rxs);
`else
    assign bit_val = rxs;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            rx_overrun_q <= 1'b0;
            rx_busy_q    <= 1'b0;
        end else begin
            frame_err_q  <= 1'b0;
            rx_overrun_q <= 1'b0;

            // Accept clears the holding register; a completing frame below
            // may override this and reload it in the same cycle.
            if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end

            if (os_tick) begin
                unique case (state_q)
                    IDLE: begin
                        if (!rxs) begin
                            state_q   <= START;
                            cnt_q     <= '0;
                            rx_busy_q <= 1'b1;
                        end
                    end

                    START: begin
                        if (cnt_q == CNT_MID) begin
                            cnt_q     <= '0;
                            bit_idx_q <= '0;
                            if (!bit_val) begin
                                state_q <= DATA;
                            end else begin
                                // Line went back high: treat as noise.
                                state_q   <= IDLE;
                                rx_busy_q <= 1'b0;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end

                    DATA: begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_q     <= '0;
                            // Shift right so the first (LSB) bit ends in bit 0.
                            shift_q   <= {bit_val, shift_q[DATA_BITS-1:1]};
                            bit_idx_q <= bit_idx_q + 1'b1;
                            if (bit_idx_q == IDX_LAST) begin
                                state_q <= STOP;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end

                    STOP: begin
                        if (cnt_q == CNT_LAST) begin
                            // Return to IDLE in the middle of the stop bit so
                            // a back-to-back start edge is caught on time.
                            cnt_q     <= '0;
                            state_q   <= IDLE;
                            rx_busy_q <= 1'b0;
                            if (bit_val) begin
                                if (!rx_valid_q || rx_ready) begin
                                    rx_data_q  <= shift_q;
                                    rx_valid_q <= 1'b1;
                                end else begin
                                    rx_overrun_q <= 1'b1;
                                end
                            end else begin
                                frame_err_q <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end

                    default: begin
                        state_q   <= IDLE;
                        cnt_q     <= '0;
                        rx_busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign frame_err  = frame_err_q;
    assign rx_overrun = rx_overrun_q;
    assign rx_busy    = rx_busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Directed bench for uart_rx with OVERSAMPLE=16 and os_tick every 4 clks.
// A single stimulus process owns every DUT input; a negedge monitor counts
// rx_valid cycles, frame_err pulses and rx_overrun pulses.
// Wire timing used for expectations: a level driven just before tick n is
// seen by the FSM on tick n+1 (two synchroniser flops), so data bit k of a
// frame whose start bit is driven before tick 0 is decided on tick 25+16k
// and the stop bit on tick 153.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       os_tick;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       rx_overrun;
    logic       rx_busy;

    int checks = 0;
    int errors = 0;

    int         valid_cnt = 0;
    int         fe_cnt    = 0;
    int         ovr_cnt   = 0;
    logic [7:0] last_data = 8'h00;
    int         div       = 0;

    always #5 clk = ~clk;

    uart_rx #(
        .DATA_BITS  (8),
        .OVERSAMPLE (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .os_tick    (os_tick),
        .rxd        (rxd),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .rx_overrun (rx_overrun),
        .rx_busy    (rx_busy)
    );

    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            valid_cnt = valid_cnt + 1;
            last_data = rx_data;
        end
        if (frame_err === 1'b1)  fe_cnt  = fe_cnt + 1;
        if (rx_overrun === 1'b1) ovr_cnt = ovr_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // One clock; os_tick is set for the coming posedge (every 4th clock).
    task automatic clk_cycle();
        @(negedge clk);
        os_tick = (div == 0);
        div = (div + 1) % 4;
    endtask

    // Returns at the negedge just before the n-th following tick edge.
    task automatic tick_wait(input int n);
        int c;
        c = 0;
        while (c < n) begin
            clk_cycle();
            if (os_tick) c = c + 1;
        end
    endtask

    task automatic clear_mon();
        valid_cnt = 0;
        fe_cnt    = 0;
        ovr_cnt   = 0;
    endtask

    // glitch_bit / abort_bit: data bit index, or 99 for none.
    // collide: pulse rx_ready for one clk on the stop-bit decision tick.
    task automatic send_frame(input logic [7:0] data, input logic stop_v,
                              input int glitch_bit, input int abort_bit,
                              input bit collide);
        logic [9:0] bits;
        bits = {stop_v, data, 1'b0};
        $display("frame data=%h stop=%0b glitch=%0d abort=%0d collide=%0b",
                 data, stop_v, glitch_bit, abort_bit, collide);
        tick_wait(1);
        for (int b = 0; b < 10; b++) begin
            rxd = bits[b];
            tick_wait(8);
            if (b >= 1 && b - 1 == abort_bit) return;
            if (b >= 1 && b - 1 == glitch_bit) begin
                rxd = ~bits[b];
                tick_wait(1);
                rxd = bits[b];
                tick_wait(7);
            end else if (b == 9 && collide) begin
                tick_wait(1);
                rx_ready = 1'b1;
                clk_cycle();
                rx_ready = 1'b0;
                tick_wait(7);
            end else begin
                tick_wait(8);
            end
        end
        rxd = 1'b1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        rxd      = 1'b1;
        rx_ready = 1'b0;
        os_tick  = 1'b0;
        repeat (3) clk_cycle();
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", rx_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
        checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", rx_overrun); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", rx_busy); end
        rst_n = 1'b1;
        tick_wait(10);
    endtask

    task automatic test_basic();
        clear_mon();
        rx_ready = 1'b1;
        send_frame(8'hA5, 1'b1, 99, 99, 1'b0);
        checks++; if (valid_cnt !== 1) begin errors++; $display("FAIL basic_valid_cycles got %0d want 1", valid_cnt); end
        checks++; if (last_data !== 8'hA5) begin errors++; $display("FAIL basic_data got %h want a5", last_data); end
        checks++; if (fe_cnt !== 0) begin errors++; $display("FAIL basic_frame_err got %0d want 0", fe_cnt); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after_mid_stop got %b want 0", rx_busy); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_cleared got %b want 0", rx_valid); end
        tick_wait(4);
    endtask

    task automatic test_false_start();
        clear_mon();
        rx_ready = 1'b1;
        tick_wait(1);
        rxd = 1'b0;
        tick_wait(4);
        checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL false_start_busy got %b want 1", rx_busy); end
        rxd = 1'b1;
        tick_wait(16);
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL false_start_idle got %b want 0", rx_busy); end
        checks++; if (valid_cnt !== 0) begin errors++; $display("FAIL false_start_valid got %0d want 0", valid_cnt); end
        send_frame(8'h3C, 1'b1, 99, 99, 1'b0);
        tick_wait(2);
        checks++; if (valid_cnt !== 1) begin errors++; $display("FAIL after_false_valid got %0d want 1", valid_cnt); end
        checks++; if (last_data !== 8'h3C) begin errors++; $display("FAIL after_false_data got %h want 3c", last_data); end
    endtask

    task automatic test_frame_err();
        clear_mon();
        rx_ready = 1'b1;
        send_frame(8'h3C, 1'b0, 99, 99, 1'b0);
        tick_wait(20);
        checks++; if (fe_cnt !== 1) begin errors++; $display("FAIL frame_err_pulses got %0d want 1", fe_cnt); end
        checks++; if (valid_cnt !== 0) begin errors++; $display("FAIL frame_err_valid got %0d want 0", valid_cnt); end
        checks++; if (ovr_cnt !== 0) begin errors++; $display("FAIL frame_err_overrun got %0d want 0", ovr_cnt); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL frame_err_idle got %b want 0", rx_busy); end
    endtask

    task automatic test_overrun();
        clear_mon();
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, 99, 99, 1'b0);
        send_frame(8'h22, 1'b1, 99, 99, 1'b0);
        tick_wait(4);
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL overrun_valid got %b want 1", rx_valid); end
        checks++; if (rx_data !== 8'h11) begin errors++; $display("FAIL overrun_data got %h want 11", rx_data); end
        checks++; if (ovr_cnt !== 1) begin errors++; $display("FAIL overrun_pulses got %0d want 1", ovr_cnt); end
        checks++; if (fe_cnt !== 0) begin errors++; $display("FAIL overrun_frame_err got %0d want 0", fe_cnt); end
        clk_cycle();
        rx_ready = 1'b1;
        clk_cycle();
        rx_ready = 1'b0;
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL overrun_accept got %b want 0", rx_valid); end
        tick_wait(4);
    endtask

    task automatic test_collision();
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, 99, 99, 1'b0);
        tick_wait(2);
        clear_mon();
        checks++; if (rx_data !== 8'h11) begin errors++; $display("FAIL collide_held got %h want 11", rx_data); end
        send_frame(8'h5A, 1'b1, 99, 99, 1'b1);
        checks++; if (rx_data !== 8'h5A) begin errors++; $display("FAIL collide_data got %h want 5a", rx_data); end
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL collide_valid got %b want 1", rx_valid); end
        checks++; if (ovr_cnt !== 0) begin errors++; $display("FAIL collide_overrun got %0d want 0", ovr_cnt); end
        clk_cycle();
        rx_ready = 1'b1;
        clk_cycle();
        rx_ready = 1'b0;
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL collide_release got %b want 0", rx_valid); end
        tick_wait(4);
    endtask

    task automatic test_reset_mid();
        rx_ready = 1'b0;
        send_frame(8'h77, 1'b1, 99, 99, 1'b0);
        send_frame(8'hC3, 1'b1, 99, 3, 1'b0);
        checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL mid_frame_busy got %b want 1", rx_busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got %b want 0", rx_valid); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL mid_reset_data got %h want 00", rx_data); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got %b want 0", rx_busy); end
        checks++; if ({frame_err, rx_overrun} !== 2'b00) begin errors++; $display("FAIL mid_reset_pulses got %b want 00", {frame_err, rx_overrun}); end
        rxd = 1'b1;
        repeat (3) clk_cycle();
        rst_n = 1'b1;
        tick_wait(20);
        clear_mon();
        rx_ready = 1'b1;
        send_frame(8'h5A, 1'b1, 99, 99, 1'b0);
        tick_wait(2);
        checks++; if (valid_cnt !== 1) begin errors++; $display("FAIL post_reset_valid got %0d want 1", valid_cnt); end
        checks++; if (last_data !== 8'h5A) begin errors++; $display("FAIL post_reset_data got %h want 5a", last_data); end
        checks++; if (fe_cnt !== 0) begin errors++; $display("FAIL post_reset_frame_err got %0d want 0", fe_cnt); end
    endtask

    task automatic test_glitch();
        logic [7:0] want;
`ifdef UART_RX_MAJORITY_EN
        want = 8'hA5;
`else
        want = 8'hA1;   // bit 2 of 0xA5 inverted by the glitch
`endif
        clear_mon();
        rx_ready = 1'b1;
        send_frame(8'hA5, 1'b1, 2, 99, 1'b0);
        tick_wait(2);
        checks++; if (valid_cnt !== 1) begin errors++; $display("FAIL glitch_valid got %0d want 1", valid_cnt); end
        checks++; if (last_data !== want) begin errors++; $display("FAIL glitch_data got %h want %h", last_data, want); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_false_start();
        test_frame_err();
        test_overrun();
        test_collision();
        test_reset_mid();
        test_glitch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
